rd_xbar: RTL and testbench

- Single-master, two-slave read-channel crossbar between the LSU read port and the memory-mapped slaves.
- Decodes each read address to the CLINT, the main memory port, or an internal decode-error responder.
- Forwards one outstanding transaction at a time.
- Buffers the slave response and holds it until the master accepts it. This tolerates slaves whose rvalid lasts only one cycle, such as the CLINT.

---
 rtl/rd_xbar.sv | 123 ++++++++++++
 tb/tb_rd_xbar.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rd_xbar.sv
// Read-channel crossbar: one LSU master, CLINT and memory slaves, plus an internal
// decode-error responder. One transaction in flight; the response is buffered until accepted.
`timescale 1ns/1ps
module rd_xbar #(
  parameter logic [31:0] CLINT_BASE = 32'h0200_0000,
  parameter logic [31:0] CLINT_MASK = 32'hFFFF_0000,
  parameter logic [31:0] MEM_BASE   = 32'h8000_0000,
  parameter logic [31:0] MEM_MASK   = 32'hF800_0000
) (
  input  logic        clock,
  input  logic        reset,
  // master read port
  input  logic        m_arvalid,
  output logic        m_arready,
  input  logic [31:0] m_araddr,
  output logic        m_rvalid,
  input  logic        m_rready,
  output logic [31:0] m_rdata,
  output logic [1:0]  m_rresp,
  // CLINT slave
  output logic        clint_arvalid,
  input  logic        clint_arready,
  output logic [31:0] clint_araddr,
  input  logic        clint_rvalid,
  output logic        clint_rready,
  input  logic [31:0] clint_rdata,
  // memory slave
  output logic        mem_arvalid,
  input  logic        mem_arready,
  output logic [31:0] mem_araddr,
  input  logic        mem_rvalid,
  output logic        mem_rready,
  input  logic [31:0] mem_rdata,
  input  logic [1:0]  mem_rresp
);

  typedef enum logic [1:0] {S_IDLE, S_AR, S_R, S_RESP} state_e;
  typedef enum logic [1:0] {T_ERR, T_CLINT, T_MEM} tgt_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  state_e      state_q;
  tgt_e        tgt_q;
  tgt_e        tgt_d;
  logic [31:0] addr_q;
  logic [31:0] rdata_q;
  logic [1:0]  rresp_q;

  logic sel_arready;
  logic sel_rvalid;

  // CLINT wins when the two regions overlap.
  function automatic tgt_e decode(input logic [31:0] addr);
    if ((addr & CLINT_MASK) == CLINT_BASE)    return T_CLINT;
    else if ((addr & MEM_MASK) == MEM_BASE)   return T_MEM;
    else                                      return T_ERR;
  endfunction

  always_comb begin
    tgt_d       = decode(m_araddr);
    sel_arready = (tgt_q == T_MEM) ? mem_arready : clint_arready;
    sel_rvalid  = (tgt_q == T_MEM) ? mem_rvalid  : clint_rvalid;
  end

  // NOTE: non-blocking assignments throughout the sequential block so every register
  // samples pre-edge values; the data buffers are reset too, so a dropped transaction
  // never leaves stale data visible on m_rdata.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      tgt_q   <= T_ERR;
      addr_q  <= '0;
      rdata_q <= '0;
      rresp_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (m_arvalid) begin
            addr_q <= m_araddr;
            tgt_q  <= tgt_d;
            if (tgt_d == T_ERR) begin
              rdata_q <= '0;
              rresp_q <= RESP_DECERR;
              state_q <= S_RESP;
            end else begin
              state_q <= S_AR;
            end
          end
        end
        S_AR: begin
          if (sel_arready) state_q <= S_R;
        end
        S_R: begin
          // Capture on the first rvalid cycle; single-cycle pulses are never missed.
          if (sel_rvalid) begin
            rdata_q <= (tgt_q == T_MEM) ? mem_rdata : clint_rdata;
            rresp_q <= (tgt_q == T_MEM) ? mem_rresp : RESP_OKAY;
            state_q <= S_RESP;
          end
        end
        S_RESP: begin
          if (m_rready) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Reset forces IDLE, so gate ready with reset to keep it low while reset is held.
  assign m_arready     = reset && (state_q == S_IDLE);
  assign m_rvalid      = (state_q == S_RESP);
  assign m_rdata       = rdata_q;
  assign m_rresp       = rresp_q;

  assign clint_arvalid = (state_q == S_AR) && (tgt_q == T_CLINT);
  assign mem_arvalid   = (state_q == S_AR) && (tgt_q == T_MEM);
  assign clint_araddr  = addr_q;
  assign mem_araddr    = addr_q;
  assign clint_rready  = (state_q == S_R) && (tgt_q == T_CLINT);
  assign mem_rready    = (state_q == S_R) && (tgt_q == T_MEM);

endmodule

// File: tb/tb_rd_xbar.sv
// Scoreboard bench for rd_xbar: directed reads push expected responses, a negedge
// monitor pops and compares on every master R handshake.
`timescale 1ns/1ps
module tb_rd_xbar;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        m_arvalid, m_arready, m_rvalid, m_rready;
  logic [31:0] m_araddr, m_rdata;
  logic [1:0]  m_rresp;
  logic        clint_arvalid, clint_arready, clint_rvalid, clint_rready;
  logic [31:0] clint_araddr, clint_rdata;
  logic        mem_arvalid, mem_arready, mem_rvalid, mem_rready;
  logic [31:0] mem_araddr, mem_rdata;
  logic [1:0]  mem_rresp;

  always #5 clock = ~clock;

  rd_xbar dut (
    .clock(clock), .reset(reset),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
    .clint_arvalid(clint_arvalid), .clint_arready(clint_arready), .clint_araddr(clint_araddr),
    .clint_rvalid(clint_rvalid), .clint_rready(clint_rready), .clint_rdata(clint_rdata),
    .mem_arvalid(mem_arvalid), .mem_arready(mem_arready), .mem_araddr(mem_araddr),
    .mem_rvalid(mem_rvalid), .mem_rready(mem_rready), .mem_rdata(mem_rdata), .mem_rresp(mem_rresp)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
  } rsp_t;
  rsp_t exp_q[$];

  // Cycle counter and event counters (sampled at negedge)
  int cyc = 0;
  int clint_ar_cyc = 0, mem_ar_cyc = 0, m_rvalid_cyc = 0, mem_rv_cyc = 0, clint_rv_cyc = 0;
  always @(posedge clock) cyc++;
  always @(negedge clock) begin
    if (clint_arvalid) clint_ar_cyc++;
    if (mem_arvalid)   mem_ar_cyc++;
    if (m_rvalid)      m_rvalid_cyc++;
    if (mem_rvalid)    mem_rv_cyc++;
    if (clint_rvalid)  clint_rv_cyc++;
  end

  // CLINT model: free-running mtime, single-cycle rvalid the cycle after the AR handshake
  logic [31:0] mtime = 32'h0001_0000;
  bit          inject_clint = 1'b0;
  logic [31:0] inject_data  = 32'hDEAD_BEEF;
  bit          clint_pend;
  logic [31:0] clint_sample;
  initial begin
    clint_rvalid = 1'b0;
    clint_rdata  = '0;
    forever begin
      @(negedge clock);
      clint_pend   = clint_arvalid && clint_arready;
      clint_sample = mtime;
      if (inject_clint) clint_pend = 1'b0;
      @(posedge clock); #1;
      clint_rvalid = clint_pend || inject_clint;
      clint_rdata  = clint_pend ? clint_sample : inject_data;
      mtime        = mtime + 32'd1;
    end
  end

  // Memory model: programmable AR delay, then a one-cycle rvalid pulse after R delay
  int          mem_ar_delay = 0;
  int          mem_r_delay  = 0;
  logic [31:0] mem_data_v   = '0;
  logic [1:0]  mem_resp_v   = '0;
  logic [31:0] mem_seen_addr = '0;
  initial begin
    mem_arready = 1'b0;
    mem_rvalid  = 1'b0;
    mem_rdata   = '0;
    mem_rresp   = '0;
    forever begin
      @(negedge clock);
      if (mem_arvalid) begin
        repeat (mem_ar_delay) begin @(posedge clock); #1; end
        mem_arready   = 1'b1;
        mem_seen_addr = mem_araddr;
        @(posedge clock); #1;
        mem_arready = 1'b0;
        repeat (mem_r_delay) begin @(posedge clock); #1; end
        mem_rvalid = 1'b1;
        mem_rdata  = mem_data_v;
        mem_rresp  = mem_resp_v;
        @(posedge clock); #1;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'hBAD0_BAD0;
        mem_rresp  = 2'b01;
      end
    end
  end

  // Monitor: scoreboard compare on R handshake, stability while stalled
  int          rhs_cyc = -100;
  bit          prev_v = 1'b0, prev_r = 1'b0;
  logic [31:0] prev_d = '0;
  logic [1:0]  prev_resp = '0;
  always @(negedge clock) begin
    rsp_t e;
    if (reset) begin
      if (prev_v && !prev_r)
        check(m_rvalid && m_rdata == prev_d && m_rresp == prev_resp, "r_stable",
              {29'd0, m_rvalid, m_rresp, m_rdata}, {29'd0, 1'b1, prev_resp, prev_d});
      if (m_rvalid && m_rready) begin
        if (exp_q.size() == 0) begin
          check(1'b0, "unexpected_rsp", {30'd0, m_rresp, m_rdata}, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check(m_rdata == e.data, "rdata", {32'd0, m_rdata}, {32'd0, e.data});
          check(m_rresp == e.resp, "rresp", {62'd0, m_rresp}, {62'd0, e.resp});
        end
        rhs_cyc = cyc;
      end
      prev_v = m_rvalid; prev_r = m_rready; prev_d = m_rdata; prev_resp = m_rresp;
    end else begin
      prev_v = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clock); #1;
  endtask

  // Issue one read; expects response latency exp_lat cycles after the master handshake.
  task automatic do_read(input logic [31:0] addr, input logic [31:0] d, input logic [1:0] r,
                         input bit is_clint, input int exp_lat, input int rr_delay, input string name);
    bit   seen;
    int   lat;
    int   arr_hi;
    rsp_t e;
    m_arvalid = 1'b1;
    m_araddr  = addr;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (m_arready) begin seen = 1'b1; break; end
      tick();
    end
    check(seen, {name, "_accept"}, 64'(seen), 64'd1);
    e.data = is_clint ? mtime + 32'd1 : d;
    e.resp = r;
    exp_q.push_back(e);
    tick();
    m_arvalid = 1'b0;
    m_araddr  = 32'hDEAD_0000;
    lat = 1; arr_hi = 0; seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (m_rvalid) begin seen = 1'b1; break; end
      if (m_arready) arr_hi++;
      tick();
      lat++;
    end
    check(seen && lat == exp_lat, {name, "_latency"}, 64'(lat), 64'(exp_lat));
    repeat (rr_delay) begin
      tick();
      if (m_arready) arr_hi++;
    end
    check(arr_hi == 0, {name, "_arready_low"}, 64'(arr_hi), 64'd0);
    tick(); m_rready = 1'b1;
    tick(); m_rready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int c_ar, m_ar, m_rv, acc, c0, n_rv, c_rv;
    bit seen;
    m_arvalid = 1'b0; m_araddr = '0; m_rready = 1'b0;
    clint_arready = 1'b1;

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    check({m_arready, m_rvalid, clint_arvalid, clint_rready, mem_arvalid, mem_rready, m_rresp, m_rdata} == '0,
          "reset_outputs", {24'd0, m_arready, m_rvalid, clint_arvalid, clint_rready, mem_arvalid, mem_rready, m_rresp, m_rdata}, 64'd0);
    reset = 1'b1;
    #1;
    check(m_arready == 1'b1, "idle_arready", 64'(m_arready), 64'd1);
    tick();

    // CLINT mtime read
    c_ar = clint_ar_cyc;
    do_read(32'h0200_0048, 32'd0, 2'b00, 1'b1, 3, 0, "clint");
    check(clint_ar_cyc - c_ar == 1, "clint_ar_pulse", 64'(clint_ar_cyc - c_ar), 64'd1);

    // Memory read with AR backpressure and master R backpressure
    mem_ar_delay = 2; mem_r_delay = 0; mem_data_v = 32'h1234_5678; mem_resp_v = 2'b00;
    m_ar = mem_ar_cyc;
    do_read(32'h8000_0010, 32'h1234_5678, 2'b00, 1'b0, 5, 4, "mem_bp");
    check(mem_ar_cyc - m_ar == 3, "mem_ar_held", 64'(mem_ar_cyc - m_ar), 64'd3);
    check(mem_seen_addr == 32'h8000_0010, "mem_araddr_latched", {32'd0, mem_seen_addr}, 64'h8000_0010);

    // Decode error
    c_ar = clint_ar_cyc; m_ar = mem_ar_cyc;
    do_read(32'h1000_0000, 32'd0, 2'b11, 1'b0, 1, 0, "decerr");
    check((clint_ar_cyc - c_ar) + (mem_ar_cyc - m_ar) == 0, "decerr_no_slave_ar",
          64'((clint_ar_cyc - c_ar) + (mem_ar_cyc - m_ar)), 64'd0);

    // Short pulse with a passed-through non-OKAY response
    mem_ar_delay = 0; mem_r_delay = 2; mem_data_v = 32'hCAFE_F00D; mem_resp_v = 2'b10;
    m_rv = mem_rv_cyc;
    do_read(32'h8765_4320, 32'hCAFE_F00D, 2'b10, 1'b0, 5, 3, "short_pulse");
    check(mem_rv_cyc - m_rv == 1, "mem_rvalid_one_cycle", 64'(mem_rv_cyc - m_rv), 64'd1);

    // Back-to-back with m_arvalid held high, spurious CLINT response during the MEM read
    mem_ar_delay = 0; mem_r_delay = 3; mem_data_v = 32'hA5A5_0001; mem_resp_v = 2'b00;
    m_rready = 1'b1; m_arvalid = 1'b1; m_araddr = 32'h0200_004C;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (m_arready) begin seen = 1'b1; break; end
      tick();
    end
    check(seen, "b2b_first_accept", 64'(seen), 64'd1);
    c0 = cyc;
    exp_q.push_back('{mtime + 32'd1, 2'b00});
    tick();
    m_araddr = 32'h8000_0000;
    exp_q.push_back('{32'hA5A5_0001, 2'b00});
    acc = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (m_arready) begin acc = cyc; break; end
      tick();
    end
    check(acc == rhs_cyc + 1, "b2b_accept_after_rhs", 64'(acc), 64'(rhs_cyc + 1));
    check(acc - c0 == 4, "b2b_accept_cycle", 64'(acc - c0), 64'd4);
    tick(); m_arvalid = 1'b0;
    c_rv = clint_rv_cyc;
    tick(); inject_clint = 1'b1;
    tick(); inject_clint = 1'b0;
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
    check(exp_q.size() == 0, "b2b_all_returned", 64'(exp_q.size()), 64'd0);
    check(clint_rv_cyc - c_rv == 1, "spurious_injected", 64'(clint_rv_cyc - c_rv), 64'd1);
    m_rready = 1'b0;
    repeat (3) tick();

    // Reset while waiting in R; late mem_rvalid must be ignored
    mem_ar_delay = 0; mem_r_delay = 4; mem_data_v = 32'h0BAD_DA7A; mem_resp_v = 2'b00;
    m_arvalid = 1'b1; m_araddr = 32'h8000_0100;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (m_arready) begin seen = 1'b1; break; end
      tick();
    end
    check(seen, "rst_accept", 64'(seen), 64'd1);
    tick(); m_arvalid = 1'b0;
    tick();
    tick();
    check(mem_rready == 1'b1, "rst_in_r_state", 64'(mem_rready), 64'd1);
    m_rv = mem_rv_cyc;
    reset = 1'b0;
    #1;
    check({m_arready, m_rvalid, clint_arvalid, clint_rready, mem_arvalid, mem_rready} == '0,
          "rst_outputs_zero", {58'd0, m_arready, m_rvalid, clint_arvalid, clint_rready, mem_arvalid, mem_rready}, 64'd0);
    tick();
    reset = 1'b1;
    #1;
    check(m_arready == 1'b1, "rst_release_arready", 64'(m_arready), 64'd1);
    n_rv = m_rvalid_cyc;
    m_rready = 1'b1;
    repeat (8) tick();
    m_rready = 1'b0;
    check(m_rvalid_cyc - n_rv == 0, "rst_no_rvalid", 64'(m_rvalid_cyc - n_rv), 64'd0);
    check(mem_rv_cyc - m_rv == 1, "rst_late_rvalid_seen", 64'(mem_rv_cyc - m_rv), 64'd1);

    // Normal operation resumes after reset
    do_read(32'h4000_0000, 32'd0, 2'b11, 1'b0, 1, 1, "post_rst");
    repeat (3) tick();
    check(exp_q.size() == 0, "scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
